// File: rtl/cnn_pkg.sv
// Shared parameters and state type for the unflatten stream slice.
package cnn_pkg;

  localparam int DATA_W = 16;
  localparam int COLS   = 11;
  localparam int ROWS   = 11;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD
  } unflat_state_t;

endpackage

// File: rtl/unflatten_stream_if.sv
// Element stream handshake: producer drives valid/data/last, consumer drives ready.
interface unflatten_stream_if #(
  parameter int DATA_W = cnn_pkg::DATA_W
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/grid_index_counter.sv
// Column-major grid index sequencer: row is the inner index, wrapping into col.
// A clear in the same cycle as an advance restarts from index 0 and steps to index 1.
module grid_index_counter #(
  parameter  int COLS = cnn_pkg::COLS,
  parameter  int ROWS = cnn_pkg::ROWS,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last_idx
);

  logic [RW-1:0] base_row;
  logic [CW-1:0] base_col;

  // Starting point for this cycle's step: zero when clearing, else the current index.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    base_row = row;
    base_col = col;
    if (clear) begin
      base_row = '0;
      base_col = '0;
    end
  end

  // Index register: step from the base on advance, or just clear.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (base_row == RW'(ROWS - 1)) begin
        row <= '0;
        col <= (base_col == CW'(COLS - 1)) ? '0 : base_col + 1'b1;
      end else begin
        row <= base_row + 1'b1;
        col <= base_col;
      end
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end
  end

  assign last_idx = (row == RW'(ROWS - 1)) && (col == CW'(COLS - 1));

endmodule

// File: rtl/unflatten_stream.sv
// Rebuilds a COLS x ROWS grid from a column-major element stream and holds it
// until the consumer acknowledges. Length mismatches against in_last are flagged.
module unflatten_stream
  import cnn_pkg::unflat_state_t;
  import cnn_pkg::IDLE;
  import cnn_pkg::FILL;
  import cnn_pkg::HOLD;
#(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int COLS   = cnn_pkg::COLS,
  parameter int ROWS   = cnn_pkg::ROWS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  unflatten_stream_if.slave        stream,
  output logic signed [DATA_W-1:0] grid_out [0:COLS-1][0:ROWS-1],
  output logic                     frame_valid,
  input  logic                     frame_ack,
  output logic                     busy,
  output logic                     len_err
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  unflat_state_t state;
  logic          ready_q;
  logic          accept;
  logic          clear;
  logic          final_elem;
  logic          last_idx;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;

  assign stream.in_ready = ready_q;
  assign accept          = stream.in_valid & ready_q;
  // start restarts the index everywhere except in HOLD without a release.
  assign clear           = start & ((state != HOLD) | frame_ack);

  grid_index_counter #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_index (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .advance  (accept),
    .row      (row),
    .col      (col),
    .last_idx (last_idx)
  );

  // Write address and final-element flag, redirected to index 0 on a resync start.
  always_comb begin
    wr_row     = row;
    wr_col     = col;
    final_elem = last_idx;
    if (start) begin
      wr_row     = '0;
      wr_col     = '0;
      final_elem = (COLS * ROWS == 1);
    end
  end

  // Frame control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ready_q     <= 1'b0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= FILL;
            ready_q <= 1'b1;
            busy    <= 1'b1;
            len_err <= 1'b0;
          end
        end
        FILL: begin
          if (accept) begin
            if (final_elem) begin
              state       <= HOLD;
              ready_q     <= 1'b0;
              busy        <= 1'b0;
              frame_valid <= 1'b1;
              len_err     <= (len_err & ~start) | ~stream.in_last;
            end else if (stream.in_last) begin
              state   <= IDLE;
              ready_q <= 1'b0;
              busy    <= 1'b0;
              len_err <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (frame_ack) begin
            frame_valid <= 1'b0;
            if (start) begin
              state   <= FILL;
              ready_q <= 1'b1;
              busy    <= 1'b1;
              len_err <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Grid storage: one flop word per cell, written when the decoded address matches.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this storage is reset because every cell must read zero after reset; plain RAM-style arrays are normally left unreset.
    if (!rst_n) begin
      for (int c = 0; c < COLS; c++) begin
        for (int r = 0; r < ROWS; r++) begin
          grid_out[c][r] <= '0;
        end
      end
    end else if (accept) begin
      for (int c = 0; c < COLS; c++) begin
        for (int r = 0; r < ROWS; r++) begin
          if (wr_col == CW'(c) && wr_row == RW'(r)) begin
            grid_out[c][r] <= stream.in_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_unflatten_stream.sv
// Directed bench for unflatten_stream: full frames, gaps, length errors,
// back-to-back frames, resync start and mid-frame reset.
module tb_unflatten_stream;

  localparam int DW = 16;
  localparam int NC = 11;
  localparam int NR = 11;

  typedef struct {
    int col;
    int row;
    int exp_val;
  } probe_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic frame_ack;
  logic frame_valid;
  logic busy;
  logic len_err;
  logic signed [DW-1:0] grid_out [0:NC-1][0:NR-1];

  int n_cmp = 0;
  int n_err = 0;
  logic fv_seen;
  probe_t probes [8];

  always #5 clk = ~clk;

  unflatten_stream_if #(.DATA_W(DW)) stream ();

  unflatten_stream #(
    .DATA_W (DW),
    .COLS   (NC),
    .ROWS   (NR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stream      (stream),
    .grid_out    (grid_out),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .busy        (busy),
    .len_err     (len_err)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Number of cells differing from scale*(11*c+r); scale 0 means all-zero grid.
  function automatic int grid_mism(input int scale);
    int m = 0;
    logic signed [31:0] v;
    for (int c = 0; c < NC; c++) begin
      for (int r = 0; r < NR; r++) begin
        v = grid_out[c][r];
        if (v !== 32'(scale * (NR * c + r))) m++;
      end
    end
    return m;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    idle(1);
    start = 1'b0;
  endtask

  // Present one element and hold it until it is accepted (bounded wait).
  task automatic send(input int data, input logic last);
    logic rdy;
    logic done = 1'b0;
    int   n = 0;
    stream.in_valid = 1'b1;
    stream.in_data  = DW'(data);
    stream.in_last  = last;
    while (!done && n < 20) begin
      rdy = stream.in_ready;
      if (frame_valid) fv_seen = 1'b1;
      idle(1);
      done = rdy;
      n++;
    end
    stream.in_valid = 1'b0;
    stream.in_last  = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  initial begin
    probes[0] = '{0, 0, 0};
    probes[1] = '{0, 10, 10};
    probes[2] = '{1, 0, 11};
    probes[3] = '{3, 4, 37};
    probes[4] = '{5, 7, 62};
    probes[5] = '{9, 2, 101};
    probes[6] = '{10, 0, 110};
    probes[7] = '{10, 10, 120};

    rst_n = 1'b0;
    start = 1'b0;
    frame_ack = 1'b0;
    stream.in_valid = 1'b0;
    stream.in_data  = '0;
    stream.in_last  = 1'b0;
    fv_seen = 1'b0;

    // Reset state
    idle(3);
    check("rst_in_ready", stream.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_len_err", len_err, 0);
    check("rst_grid_zero", grid_mism(0), 0);
    rst_n = 1'b1;
    idle(1);

    // Frame 1: contiguous ramp, in_last on k=120
    pulse_start();
    check("f1_busy", busy, 1);
    check("f1_in_ready", stream.in_ready, 1);
    for (int k = 0; k < 120; k++) send(k, 1'b0);
    check("f1_fv_before_last", frame_valid, 0);
    send(120, 1'b1);
    check("f1_frame_valid", frame_valid, 1);
    check("f1_len_err", len_err, 0);
    check("f1_in_ready_hold", stream.in_ready, 0);
    check("f1_grid", grid_mism(1), 0);
    for (int i = 0; i < 8; i++)
      check($sformatf("f1_cell_%0d_%0d", probes[i].col, probes[i].row),
            grid_out[probes[i].col][probes[i].row], probes[i].exp_val);
    frame_ack = 1'b1;
    idle(1);
    frame_ack = 1'b0;
    check("f1_fv_after_ack", frame_valid, 0);
    check("f1_idle_busy", busy, 0);

    // Frame 2: random gaps, long hold with ignored start and blocked data
    pulse_start();
    for (int k = 0; k <= 120; k++) begin
      idle($urandom_range(0, 2));
      send(k, k == 120);
    end
    for (int i = 0; i < 10; i++) begin
      check($sformatf("f2_hold_ready_%0d", i), stream.in_ready, 0);
      check($sformatf("f2_hold_fv_%0d", i), frame_valid, 1);
      start = (i == 4);
      stream.in_valid = (i >= 4 && i <= 6);
      stream.in_data  = 16'sd9999;
      idle(1);
    end
    start = 1'b0;
    stream.in_valid = 1'b0;
    check("f2_grid", grid_mism(1), 0);
    check("f2_start_ignored_busy", busy, 0);
    frame_ack = 1'b1;
    idle(1);
    frame_ack = 1'b0;
    check("f2_fv_after_ack", frame_valid, 0);

    // Early in_last at k=50 with data 1000+k
    fv_seen = 1'b0;
    pulse_start();
    for (int k = 0; k <= 50; k++) send(1000 + k, k == 50);
    check("early_len_err", len_err, 1);
    check("early_idle_busy", busy, 0);
    check("early_in_ready", stream.in_ready, 0);
    check("early_fv", frame_valid, 0);
    check("early_fv_seen", fv_seen, 0);
    check("early_cell_4_6", grid_out[4][6], 1050);
    check("early_cell_4_7", grid_out[4][7], 51);

    // No in_last at all; frame_ack during FILL must be ignored
    pulse_start();
    check("nolast_len_err_cleared", len_err, 0);
    for (int k = 0; k <= 120; k++) begin
      frame_ack = (k == 30);
      send(k, 1'b0);
      if (k == 30) check("nolast_ack_ignored_busy", busy, 1);
    end
    frame_ack = 1'b0;
    check("nolast_len_err", len_err, 1);
    check("nolast_fv", frame_valid, 1);
    check("nolast_grid", grid_mism(1), 0);

    // frame_ack + start in HOLD: straight into the next frame with data=-k
    frame_ack = 1'b1;
    start = 1'b1;
    idle(1);
    frame_ack = 1'b0;
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_in_ready", stream.in_ready, 1);
    check("b2b_fv", frame_valid, 0);
    check("b2b_len_err", len_err, 0);
    for (int k = 0; k <= 120; k++) send(-k, k == 120);
    check("b2b_cell_10_10", grid_out[10][10], -120);
    check("b2b_grid", grid_mism(-1), 0);
    check("b2b_fv_done", frame_valid, 1);
    check("b2b_len_err_done", len_err, 0);
    frame_ack = 1'b1;
    idle(1);
    frame_ack = 1'b0;

    // Resync start mid-FILL, then reset at k=60
    pulse_start();
    for (int k = 0; k < 5; k++) send(500 + k, 1'b0);
    start = 1'b1;
    send(777, 1'b0);
    start = 1'b0;
    send(778, 1'b0);
    check("resync_cell_0_0", grid_out[0][0], 777);
    check("resync_cell_0_1", grid_out[0][1], 778);
    check("resync_cell_0_2", grid_out[0][2], 502);
    check("resync_busy", busy, 1);
    for (int k = 2; k <= 60; k++) send(k, 1'b0);
    check("resync_cell_5_5", grid_out[5][5], 60);
    check("resync_cell_0_2_new", grid_out[0][2], 2);
    rst_n = 1'b0;
    #1;
    check("mrst_in_ready", stream.in_ready, 0);
    check("mrst_busy", busy, 0);
    check("mrst_fv", frame_valid, 0);
    check("mrst_len_err", len_err, 0);
    check("mrst_grid_zero", grid_mism(0), 0);
    idle(2);
    rst_n = 1'b1;
    stream.in_valid = 1'b1;
    stream.in_data  = 16'sd1234;
    fv_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("post_rst_ready_%0d", i), stream.in_ready, 0);
      idle(1);
    end
    stream.in_valid = 1'b0;
    check("post_rst_grid_zero", grid_mism(0), 0);
    check("post_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/unflatten_stream.md
UNFLATTEN_STREAM -- requirements
Module: unflatten_stream

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the signed element width.
REQ-002 The block SHALL have parameter COLS, default 11, meaning the grid column count.
REQ-003 The block SHALL have parameter ROWS, default 11, meaning the grid row count.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, meaning the asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit, meaning arm the block to receive one frame.
REQ-007 The block SHALL have port in_valid, input, 1 bit, meaning in_data is valid this cycle.
REQ-008 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts an element this cycle.
REQ-009 The block SHALL have port in_data, input, signed DATA_W, meaning the flat element stream in column-major order.
REQ-010 The block SHALL have port in_last, input, 1 bit, meaning the producer marks this element as the final one of the frame.
REQ-011 The block SHALL have port grid_out, output, signed DATA_W [0:COLS-1][0:ROWS-1], meaning the reconstructed grid.
REQ-012 The block SHALL have port frame_valid, output, 1 bit, meaning grid_out holds a complete frame.
REQ-013 The block SHALL have port frame_ack, input, 1 bit, meaning the consumer releases the frame.
REQ-014 The block SHALL have port busy, output, 1 bit, meaning the block is in the FILL state.
REQ-015 The block SHALL have port len_err, output, 1 bit, meaning a sticky in_last/length mismatch flag.

Function
REQ-016 The state machine SHALL have exactly three states: IDLE, FILL and HOLD.
REQ-017 An element SHALL be accepted only when in_valid and in_ready are both high in the same cycle.
REQ-018 in_ready and busy SHALL be registered and SHALL be high only in FILL.
REQ-019 The k-th accepted element (k = 0..COLS*ROWS-1) SHALL be written to grid_out[k / ROWS][k % ROWS]; the row index is the inner index and wraps ROWS-1->0 with a column increment.
REQ-020 In IDLE, start SHALL clear row, column and len_err and move the block to FILL on the next cycle.
REQ-021 Acceptance of element index COLS*ROWS-1 SHALL move the block to HOLD, with frame_valid high on the following cycle (1-cycle latency).
REQ-022 Acceptance of the final element with in_last low SHALL set len_err, and the block SHALL still enter HOLD.
REQ-023 Acceptance of a non-final element with in_last high SHALL set len_err, return the block to IDLE and leave frame_valid low; any partially written cells SHALL retain their new values.
REQ-024 In HOLD, grid_out SHALL be stable, in_ready SHALL be low, and frame_valid SHALL stay high until frame_ack.
REQ-025 In HOLD, frame_ack SHALL return the block to IDLE with frame_valid low on the next cycle.
REQ-026 In HOLD, frame_ack together with start in the same cycle SHALL move the block directly to FILL with counters and len_err cleared.
REQ-027 In HOLD, start without frame_ack SHALL be ignored.
REQ-028 In FILL, start SHALL resynchronise: counters are cleared, the block stays in FILL, and any element accepted in that same cycle is written to [0][0] and advances the counters to index 1.
REQ-029 frame_ack outside HOLD SHALL be ignored.
REQ-030 in_data SHALL be stored bit-exact with no arithmetic, sign change or width change.

Reset
REQ-031 While rst_n is low, the block SHALL hold state IDLE, counters 0, in_ready 0, busy 0, frame_valid 0, len_err 0 and every grid_out cell 0.
REQ-032 Reset asserted mid-FILL or mid-HOLD SHALL abandon the frame immediately; no acceptance SHALL occur until a new start.

Structure
REQ-033 The shared package cnn_pkg SHALL hold DATA_W, COLS, ROWS and the state enum typedef unflat_state_t.
REQ-034 Index sequencing SHALL be in one sub-module, grid_index_counter, which provides clear/advance inputs and row, col and last_idx outputs, with the row wrap and column increment inside it.
REQ-035 The grid storage SHALL be flops with per-cell write enable decoded from row and col.

Verification
REQ-036 The bench SHALL drive reset, start, then 121 elements k=0..120 with data=k and in_last only on k=120, and SHALL check grid_out[c][r]==11*c+r, frame_valid one cycle after k=120 and len_err 0.
REQ-037 The bench SHALL repeat the stream with random in_valid gaps and frame_ack held low 10 cycles, and SHALL check identical grid, in_ready low throughout HOLD and frame_valid dropping the cycle after frame_ack.
REQ-038 The bench SHALL send in_last at k=50, and SHALL check len_err 1, state IDLE, frame_valid never high and in_ready 0.
REQ-039 The bench SHALL send 121 elements with in_last never asserted, and SHALL check len_err 1, frame_valid 1 and a correct grid.
REQ-040 The bench SHALL pulse frame_ack together with start in HOLD, then send a second frame with data=-k, and SHALL check grid_out[10][10]==-120 and no idle cycle between frames.
REQ-041 The bench SHALL assert rst_n low at k=60, and SHALL check all outputs 0 and that in_valid after reset without start is not accepted.
